ddr_write_arbiter: RTL and testbench
====================================

Name: ddr_write_arbiter

Overview:
Shares one DDR AXI write-master command/data port between g_NUM_REQ frame-writer requesters, e.g. several camera/ISP write paths.
- Each requester presents the same command interface the frame writers already drive: write_req, write_start_addr, burst_size, data, data_rdy.
- Round-robin grant is held for one full burst, from request to write_done.
- Ack and done handshakes are routed back to the granted requester only.
- Sits in the DDR clock domain, between the writers and the AXI write master.

Parameters:
g_NUM_REQ, 2, number of requesters (legal 2..4).
g_DDR_AXI_DWIDTH, 512, data width per requester.
g_ADDR_WIDTH, 38, DDR start address width.
g_TIMEOUT, 4096, watchdog limit in ddr_clk_i cycles (used only with the optional feature).

Ports:
ddr_clk_i  in  1  DDR-domain clock; single clock for the whole block.
ddr_clk_rstn_i  in  1  reset; synchronous, active-low.
req_i  in  g_NUM_REQ  per-requester write request; held high until its ackn_o pulse.
start_addr_i  in  g_NUM_REQ*g_ADDR_WIDTH  packed start addresses; requester k at slice k.
burst_size_i  in  g_NUM_REQ*8  packed burst sizes.
data_i  in  g_NUM_REQ*g_DDR_AXI_DWIDTH  packed write data.
data_rdy_i  in  g_NUM_REQ  per-requester data-ready.
ackn_o  out  g_NUM_REQ  one-hot ack pulse to the granted requester.
done_o  out  g_NUM_REQ  one-hot done pulse to the granted requester.
grant_o  out  g_NUM_REQ  one-hot current grant; 0 when idle.
write_req_o  out  1  request to the AXI write master.
write_start_addr_o  out  g_ADDR_WIDTH  registered start address of the granted command.
burst_size_o  out  8  registered burst size of the granted command.
data_o  out  g_DDR_AXI_DWIDTH  data_i slice of the granted requester.
data_rdy_o  out  1  data_rdy_i of the granted requester; 0 when idle.
write_ackn_i  in  1  AXI write master accepted the command.
write_done_i  in  1  AXI write master finished the burst.

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer = g_NUM_REQ-1, so requester 0 wins first.
- FSM states are IDLE, ISSUE and BURST.
- IDLE:
  - If req_i != 0, pick the first set bit searching upward from last+1, wrapping modulo g_NUM_REQ.
  - Register grant_o, write_start_addr_o and burst_size_o from that requester's slices, and set write_req_o=1.
  - Go to ISSUE. write_req_o is high on the cycle after req_i is first seen (1-cycle latency).
- ISSUE:
  - write_req_o stays 1 and the address/size registers are frozen until write_ackn_i.
  - On write_ackn_i: ackn_o[grant] pulses 1 cycle (registered), write_req_o=0 next cycle, go to BURST.
- BURST:
  - On write_done_i: done_o[grant] pulses 1 cycle, last pointer = grant, grant_o=0, go to IDLE.
- Minimum of 1 IDLE cycle between bursts; a requester never sees back-to-back grants within 1 cycle.
- data_o and data_rdy_o are combinational muxes on the registered grant_o. When grant_o=0: data_o=0 and data_rdy_o=0.
- Simultaneous write_ackn_i and write_done_i in ISSUE: both pulses fire on the same cycle and the FSM goes directly to IDLE with the pointer updated.
- write_ackn_i outside ISSUE and write_done_i in IDLE are ignored.
- If req_i of the granted requester drops during ISSUE or BURST, this is a protocol violation. The grant is held and the transaction completes anyway.
- Round-robin fairness: with all requests continuously high, grants cycle 0,1,..,N-1,0.
- Reset mid-operation: on the next edge the block returns to the reset values. Pending pulses are dropped and write_req_o is deasserted.

Optional Feature:
Macro DDR_WRITE_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to ISSUE and increments every cycle in ISSUE and BURST.
  - On reaching g_TIMEOUT: force write_req_o=0, grant_o=0, go to IDLE, update the pointer to the hung requester, and pulse timeout_o (out, 1) for 1 cycle.
  - No ackn_o or done_o pulse is issued for the aborted transaction.
- Undefined: no counter and no timeout_o port; the block waits indefinitely.

Test Plan:
1. Reset, then req_i=2'b01 with addr 0x0_1000_0000 and burst 8'd60. Required: write_req_o=1 one cycle later with that address and burst; write_ackn_i gives ackn_o=01 for 1 cycle; write_done_i gives done_o=01 and grant_o=00.
2. req_i=2'b11 held for 4 bursts. Required: grant order 01,10,01,10; ≥1 idle cycle between bursts.
3. Requester 1 alone with the pointer at 1. Required: requester 1 is granted, wrapping past requester 0.
4. write_ackn_i and write_done_i asserted together in ISSUE. Required: ackn_o and done_o pulse on the same cycle and the FSM returns to IDLE.
5. ddr_clk_rstn_i=0 during BURST. Required: next cycle all outputs 0; after release, requester 0 is granted first.
6. With DDR_WRITE_ARB_TIMEOUT_EN and g_TIMEOUT=16, no write_done_i after ack. Required: timeout_o pulses 16 cycles after ISSUE entry, grant_o=0, and the other requester is granted next.

Source files
------------

// File: rtl/ddr_write_arbiter_if.sv
// Bundle of requester-side and AXI-write-master-side signals of ddr_write_arbiter.
// DDR_WRITE_ARB_TIMEOUT_EN adds the timeout_o pulse.
interface ddr_write_arbiter_if #(
  parameter int g_NUM_REQ        = 2,
  parameter int g_DDR_AXI_DWIDTH = 512,
  parameter int g_ADDR_WIDTH     = 38
);
  logic [g_NUM_REQ-1:0]                  req_i;
  logic [g_NUM_REQ*g_ADDR_WIDTH-1:0]     start_addr_i;
  logic [g_NUM_REQ*8-1:0]                burst_size_i;
  logic [g_NUM_REQ*g_DDR_AXI_DWIDTH-1:0] data_i;
  logic [g_NUM_REQ-1:0]                  data_rdy_i;
  logic [g_NUM_REQ-1:0]                  ackn_o;
  logic [g_NUM_REQ-1:0]                  done_o;
  logic [g_NUM_REQ-1:0]                  grant_o;
  logic                                  write_req_o;
  logic [g_ADDR_WIDTH-1:0]               write_start_addr_o;
  logic [7:0]                            burst_size_o;
  logic [g_DDR_AXI_DWIDTH-1:0]           data_o;
  logic                                  data_rdy_o;
  logic                                  write_ackn_i;
  logic                                  write_done_i;
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
  logic                                  timeout_o;
`endif

  // Environment side: requesters plus the AXI write master.
  modport master (
    output req_i, start_addr_i, burst_size_i, data_i, data_rdy_i,
    output write_ackn_i, write_done_i,
    input  ackn_o, done_o, grant_o, write_req_o, write_start_addr_o,
    input  burst_size_o, data_o, data_rdy_o
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
    , input timeout_o
`endif
  );

  // Arbiter side.
  modport slave (
    input  req_i, start_addr_i, burst_size_i, data_i, data_rdy_i,
    input  write_ackn_i, write_done_i,
    output ackn_o, done_o, grant_o, write_req_o, write_start_addr_o,
    output burst_size_o, data_o, data_rdy_o
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
    , output timeout_o
`endif
  );
endinterface

// File: rtl/ddr_write_arbiter.sv
// Round-robin arbiter sharing one DDR AXI write-master command port among frame writers.
// Optional watchdog abort enabled by defining DDR_WRITE_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin from last+1
// ISSUE | command presented on write_req_o, waiting for write_ackn_i
// BURST | command accepted, waiting for write_done_i
module ddr_write_arbiter #(
  parameter int g_NUM_REQ        = 2,
  parameter int g_DDR_AXI_DWIDTH = 512,
  parameter int g_ADDR_WIDTH     = 38,
  parameter int g_TIMEOUT        = 4096
) (
  input logic ddr_clk_i,
  input logic ddr_clk_rstn_i,
  ddr_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(g_NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t                      state_q;
  logic [PW-1:0]               last_q;
  logic [PW-1:0]               gnt_idx_q;
  logic [g_NUM_REQ-1:0]        grant_q;
  logic                        wreq_q;
  logic [g_ADDR_WIDTH-1:0]     addr_q;
  logic [7:0]                  bsz_q;
  logic [g_NUM_REQ-1:0]        ackn_q;
  logic [g_NUM_REQ-1:0]        done_q;
  logic [PW-1:0]               pick_idx;
  logic                        pick_vld;
  logic [g_DDR_AXI_DWIDTH-1:0] data_mux;
  logic                        rdy_mux;
  int                          k;

`ifdef DDR_WRITE_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(g_TIMEOUT - 1);
  logic [15:0] wdog_q;
  logic        tmo_q;
`endif

  // First requesting index searching upward from last+1 with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    k        = 0;
    for (int i = 1; i <= g_NUM_REQ; i++) begin
      k = (int'(last_q) + i) % g_NUM_REQ;
      if (!pick_vld && bus.req_i[k]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(k);
      end
    end
  end

  always_comb begin
    data_mux = '0;
    rdy_mux  = 1'b0;
    for (int i = 0; i < g_NUM_REQ; i++) begin
      if (grant_q[i]) begin
        data_mux = data_mux | bus.data_i[i*g_DDR_AXI_DWIDTH +: g_DDR_AXI_DWIDTH];
        rdy_mux  = rdy_mux | bus.data_rdy_i[i];
      end
    end
  end

  always_ff @(posedge ddr_clk_i) begin
    if (!ddr_clk_rstn_i) begin
      state_q   <= IDLE;
      last_q    <= PW'(g_NUM_REQ - 1);
      gnt_idx_q <= '0;
      grant_q   <= '0;
      wreq_q    <= 1'b0;
      addr_q    <= '0;
      bsz_q     <= '0;
      ackn_q    <= '0;
      done_q    <= '0;
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
      wdog_q    <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      ackn_q <= '0;
      done_q <= '0;
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_idx_q <= pick_idx;
            grant_q   <= g_NUM_REQ'(1) << pick_idx;
            addr_q    <= bus.start_addr_i[pick_idx*g_ADDR_WIDTH +: g_ADDR_WIDTH];
            bsz_q     <= bus.burst_size_i[pick_idx*8 +: 8];
            wreq_q    <= 1'b1;
            state_q   <= ISSUE;
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
            wdog_q    <= '0;
`endif
          end
        end
        ISSUE: begin
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
          wdog_q <= wdog_q + 16'd1;
`endif
          if (bus.write_ackn_i) begin
            ackn_q[gnt_idx_q] <= 1'b1;
            wreq_q            <= 1'b0;
            // A done arriving with the ack closes the burst immediately.
            if (bus.write_done_i) begin
              done_q[gnt_idx_q] <= 1'b1;
              grant_q           <= '0;
              last_q            <= gnt_idx_q;
              state_q           <= IDLE;
            end else begin
              state_q <= BURST;
            end
          end
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
          else if (wdog_q == TMO_LAST) begin
            wreq_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= gnt_idx_q;
            tmo_q   <= 1'b1;
            state_q <= IDLE;
          end
`endif
        end
        BURST: begin
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
          wdog_q <= wdog_q + 16'd1;
`endif
          if (bus.write_done_i) begin
            done_q[gnt_idx_q] <= 1'b1;
            grant_q           <= '0;
            last_q            <= gnt_idx_q;
            state_q           <= IDLE;
          end
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
          else if (wdog_q == TMO_LAST) begin
            grant_q <= '0;
            last_q  <= gnt_idx_q;
            tmo_q   <= 1'b1;
            state_q <= IDLE;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ackn_o             = ackn_q;
  assign bus.done_o             = done_q;
  assign bus.grant_o            = grant_q;
  assign bus.write_req_o        = wreq_q;
  assign bus.write_start_addr_o = addr_q;
  assign bus.burst_size_o       = bsz_q;
  assign bus.data_o             = data_mux;
  assign bus.data_rdy_o         = rdy_mux;
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
  assign bus.timeout_o          = tmo_q;
`endif
endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Directed scoreboard bench for ddr_write_arbiter with two requesters.
// The watchdog step runs only when DDR_WRITE_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ddr_write_arbiter;
  localparam int NR = 2;
  localparam int DW = 64;
  localparam int AW = 38;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [7:0]    bsz;
  } exp_t;
  exp_t exp_q[$];

  logic [AW-1:0] addr_k [NR];
  logic [7:0]    bsz_k  [NR];
  logic [DW-1:0] dat_k  [NR];
  logic [NR-1:0] rdy_k;

  ddr_write_arbiter_if #(.g_NUM_REQ(NR), .g_DDR_AXI_DWIDTH(DW), .g_ADDR_WIDTH(AW)) bus ();

  ddr_write_arbiter #(
    .g_NUM_REQ(NR), .g_DDR_AXI_DWIDTH(DW), .g_ADDR_WIDTH(AW), .g_TIMEOUT(16)
  ) dut (
    .ddr_clk_i(clk),
    .ddr_clk_rstn_i(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "simulation time bound exceeded");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ackn"}, 64'(bus.ackn_o), 0);
    chk({tag, "_done"}, 64'(bus.done_o), 0);
    chk({tag, "_grant"}, 64'(bus.grant_o), 0);
    chk({tag, "_wreq"}, 64'(bus.write_req_o), 0);
    chk({tag, "_addr"}, 64'(bus.write_start_addr_o), 0);
    chk({tag, "_bsz"}, 64'(bus.burst_size_o), 0);
    chk({tag, "_data"}, bus.data_o, 0);
    chk({tag, "_rdy"}, 64'(bus.data_rdy_o), 0);
`ifdef DDR_WRITE_ARB_TIMEOUT_EN
    chk({tag, "_tmo"}, 64'(bus.timeout_o), 0);
`endif
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.idx  = idx;
    e.addr = addr_k[idx];
    e.bsz  = bsz_k[idx];
    exp_q.push_back(e);
  endtask

  // Wait for a command, pop the expected grant and check the presented command.
  task automatic take_cmd(output exp_t e, output bit ok);
    int w;
    w  = 0;
    ok = 1'b0;
    while (bus.write_req_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("wreq_wait", 64'(bus.write_req_o), 1);
    if (bus.write_req_o !== 1'b1) return;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_empty: observed unexpected command expected none");
      return;
    end
    e = exp_q.pop_front();
    chk("cmd_grant", 64'(bus.grant_o), 64'(2'b01 << e.idx));
    chk("cmd_addr", 64'(bus.write_start_addr_o), 64'(e.addr));
    chk("cmd_bsz", 64'(bus.burst_size_o), 64'(e.bsz));
    chk("cmd_data", bus.data_o, dat_k[e.idx]);
    chk("cmd_rdy", 64'(bus.data_rdy_o), 64'(rdy_k[e.idx]));
    ok = 1'b1;
  endtask

  task automatic serve(input bit together, input bit drop, input bit release_req);
    exp_t e;
    bit   ok;
    logic [1:0] oh;
    take_cmd(e, ok);
    if (!ok) return;
    oh = 2'b01 << e.idx;
    if (drop) begin
      bus.req_i[e.idx] = 1'b0;
      @(negedge clk);
      chk("drop_grant_held", 64'(bus.grant_o), 64'(oh));
      chk("drop_wreq_held", 64'(bus.write_req_o), 1);
    end
    bus.write_ackn_i = 1'b1;
    bus.write_done_i = together;
    @(negedge clk);
    bus.write_ackn_i = 1'b0;
    bus.write_done_i = 1'b0;
    if (release_req) bus.req_i[e.idx] = 1'b0;
    chk("ackn_pulse", 64'(bus.ackn_o), 64'(oh));
    chk("wreq_drop", 64'(bus.write_req_o), 0);
    if (together) begin
      chk("tog_done", 64'(bus.done_o), 64'(oh));
      chk("tog_grant", 64'(bus.grant_o), 0);
    end else begin
      @(negedge clk);
      chk("ackn_1cyc", 64'(bus.ackn_o), 0);
      chk("burst_grant", 64'(bus.grant_o), 64'(oh));
      bus.write_done_i = 1'b1;
      @(negedge clk);
      bus.write_done_i = 1'b0;
      chk("done_pulse", 64'(bus.done_o), 64'(oh));
      chk("idle_grant", 64'(bus.grant_o), 0);
      chk("idle_data", bus.data_o, 0);
      chk("idle_rdy", 64'(bus.data_rdy_o), 0);
    end
  endtask

  initial begin
    exp_t e;
    bit   ok;
    int   cnt;
    addr_k[0] = 38'h0_1000_0000; bsz_k[0] = 8'd60;
    addr_k[1] = 38'h2_3456_7800; bsz_k[1] = 8'd128;
    dat_k[0]  = 64'hA5A5_0000_1111_2222;
    dat_k[1]  = 64'h5A5A_3333_4444_5555;
    rdy_k     = 2'b10;
    bus.req_i        = '0;
    bus.start_addr_i = {addr_k[1], addr_k[0]};
    bus.burst_size_i = {bsz_k[1], bsz_k[0]};
    bus.data_i       = {dat_k[1], dat_k[0]};
    bus.data_rdy_i   = rdy_k;
    bus.write_ackn_i = 1'b0;
    bus.write_done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;

    // Single requester 0 with 1-cycle command latency.
    @(negedge clk);
    bus.req_i = 2'b01;
    push(0);
    @(negedge clk);
    chk("t1_latency", 64'(bus.write_req_o), 1);
    serve(1'b0, 1'b0, 1'b1);

    // Stray ack/done while idle are ignored.
    @(negedge clk);
    bus.write_ackn_i = 1'b1;
    bus.write_done_i = 1'b1;
    @(negedge clk);
    bus.write_ackn_i = 1'b0;
    bus.write_done_i = 1'b0;
    chk("stray_ackn", 64'(bus.ackn_o), 0);
    chk("stray_done", 64'(bus.done_o), 0);
    chk("stray_wreq", 64'(bus.write_req_o), 0);

    // Fairness from reset: both held, grants 0,1,0,1.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    bus.req_i = 2'b11;
    push(0); push(1); push(0); push(1);
    repeat (4) serve(1'b0, 1'b0, 1'b0);
    bus.req_i = 2'b00;

    // Pointer at 1: requester 1 alone wraps past 0; dropped request keeps grant.
    @(negedge clk);
    bus.req_i = 2'b10;
    push(1);
    serve(1'b0, 1'b1, 1'b1);

    // Ack and done together.
    @(negedge clk);
    bus.req_i = 2'b01;
    push(0);
    serve(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("tog_idle_wreq", 64'(bus.write_req_o), 0);
    chk("tog_idle_done", 64'(bus.done_o), 0);

    // Pointer now 0: requester 1 next; reset mid-burst.
    bus.req_i = 2'b11;
    push(1);
    take_cmd(e, ok);
    bus.write_ackn_i = 1'b1;
    @(negedge clk);
    bus.write_ackn_i = 1'b0;
    chk("t5_ackn", 64'(bus.ackn_o), 64'(2'b10));
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rstn = 1'b1;
    push(0);
    serve(1'b0, 1'b0, 1'b1);
    bus.req_i = 2'b00;

`ifdef DDR_WRITE_ARB_TIMEOUT_EN
    // Watchdog: requester 1 hangs after ack, requester 0 follows.
    @(negedge clk);
    bus.req_i = 2'b11;
    push(1);
    take_cmd(e, ok);
    bus.write_ackn_i = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cnt = i;
      if (i == 1) begin
        bus.write_ackn_i = 1'b0;
        chk("t6_ackn", 64'(bus.ackn_o), 64'(2'b10));
      end
      if (bus.timeout_o === 1'b1) break;
    end
    chk("t6_cycles", 64'(cnt), 16);
    chk("t6_grant", 64'(bus.grant_o), 0);
    chk("t6_wreq", 64'(bus.write_req_o), 0);
    chk("t6_done", 64'(bus.done_o), 0);
    @(negedge clk);
    chk("t6_tmo_1cyc", 64'(bus.timeout_o), 0);
    push(0);
    serve(1'b0, 1'b0, 1'b1);
    bus.req_i = 2'b00;
`endif

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
